// File: rtl/uc_executa_rota_if.sv
// Route RAM port between the route executor (master) and the route RAM (slave).
// The executor presents the head address and clear strobe; the RAM returns the entry one cycle later.
interface uc_executa_rota_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] head_addr;
  logic              clear_entry;
  logic              rd_valid;
  logic [3:0]        rd_floor;

  modport master (
    output head_addr,
    output clear_entry,
    input  rd_valid,
    input  rd_floor
  );

  modport slave (
    input  head_addr,
    input  clear_entry,
    output rd_valid,
    output rd_floor
  );
endinterface

// File: rtl/uc_executa_rota.sv
// Route executor: fetches the stop at the head of the route RAM, drives the car there, opens the door, pops the entry.
// Optional macro DOOR_HOLD_EN adds a door_hold input that restarts the door timer while asserted.
module uc_executa_rota #(
  parameter int N_FLOORS = 8,
  parameter int ADDR_W   = 4,
  parameter int T_FLOOR  = 50,
  parameter int T_DOOR   = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              insert_busy,
`ifdef DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  uc_executa_rota_if.master ram,
  output logic [3:0]        current_floor,
  output logic              move_up,
  output logic              move_down,
  output logic              door_open,
  output logic              bad_stop,
  output logic [3:0]        state_db
);

  localparam int TF_W = (T_FLOOR > 1) ? $clog2(T_FLOOR) : 1;
  localparam int TD_W = (T_DOOR > 1) ? $clog2(T_DOOR) : 1;
  localparam logic [TF_W-1:0] TF_LAST   = TF_W'(T_FLOOR - 1);
  localparam logic [TD_W-1:0] TD_LAST   = TD_W'(T_DOOR - 1);
  localparam logic [4:0]      FLOOR_LIM = 5'(N_FLOORS);
  localparam logic [3:0]      TOP_FLOOR = 4'(N_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    FETCH  = 3'd2,
    DECIDE = 3'd3,
    UP     = 3'd4,
    DOWN   = 3'd5,
    DOOR   = 3'd6,
    POP    = 3'd7
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] head_reg, head_next;
  logic [3:0]        floor_reg, floor_next;
  logic [3:0]        target_reg, target_next;
  logic              bad_reg, bad_next;
  logic [TF_W-1:0]   travel_cnt_reg, travel_cnt_next;
  logic [TD_W-1:0]   door_cnt_reg, door_cnt_next;
  logic [3:0]        floor_step;
  logic              hold;

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      head_reg       <= '0;
      floor_reg      <= '0;
      target_reg     <= '0;
      bad_reg        <= 1'b0;
      travel_cnt_reg <= '0;
      door_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      head_reg       <= head_next;
      floor_reg      <= floor_next;
      target_reg     <= target_next;
      bad_reg        <= bad_next;
      travel_cnt_reg <= travel_cnt_next;
      door_cnt_reg   <= door_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    head_next       = head_reg;
    floor_next      = floor_reg;
    target_next     = target_reg;
    bad_next        = bad_reg;
    travel_cnt_next = travel_cnt_reg;
    door_cnt_next   = door_cnt_reg;
    floor_step      = floor_reg;

    case (state_reg)
      IDLE: begin
        if (iniciar) state_next = READ;
      end
      READ: begin
        state_next = FETCH;
      end
      FETCH: begin
        target_next = ram.rd_floor;
        bad_next    = 1'b0;
        if (!ram.rd_valid) begin
          state_next = IDLE;
        end else if ({1'b0, ram.rd_floor} >= FLOOR_LIM) begin
          bad_next   = 1'b1;
          state_next = POP;
        end else begin
          state_next = DECIDE;
        end
      end
      DECIDE: begin
        travel_cnt_next = '0;
        door_cnt_next   = '0;
        if (target_reg > floor_reg)      state_next = UP;
        else if (target_reg < floor_reg) state_next = DOWN;
        else                             state_next = DOOR;
      end
      UP, DOWN: begin
        if (travel_cnt_reg == TF_LAST) begin
          travel_cnt_next = '0;
          // Saturating step; the range check in FETCH keeps the target reachable.
          if (state_reg == UP)
            floor_step = (floor_reg == TOP_FLOOR) ? floor_reg : floor_reg + 4'd1;
          else
            floor_step = (floor_reg == 4'd0) ? floor_reg : floor_reg - 4'd1;
          floor_next = floor_step;
          if (floor_step == target_reg) state_next = DOOR;
        end else begin
          travel_cnt_next = travel_cnt_reg + TF_W'(1);
        end
      end
      DOOR: begin
        if (hold) begin
          door_cnt_next = '0;
        end else if (door_cnt_reg == TD_LAST) begin
          door_cnt_next = '0;
          state_next    = POP;
        end else begin
          door_cnt_next = door_cnt_reg + TD_W'(1);
        end
      end
      POP: begin
        // The insertion FSM owns the RAM write port while busy.
        if (!insert_busy) begin
          head_next  = head_reg + ADDR_W'(1);
          bad_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    move_up         = 1'b0;
    move_down       = 1'b0;
    door_open       = 1'b0;
    ram.clear_entry = 1'b0;
    bad_stop        = 1'b0;
    case (state_reg)
      UP:   move_up   = 1'b1;
      DOWN: move_down = 1'b1;
      DOOR: door_open = 1'b1;
      POP: begin
        ram.clear_entry = !insert_busy;
        bad_stop        = !insert_busy && bad_reg;
      end
      default: ;
    endcase
  end

  assign ram.head_addr  = head_reg;
  assign current_floor  = floor_reg;
  assign state_db       = {1'b0, state_reg};

endmodule

// File: tb/tb_uc_executa_rota.sv
// Directed bench for uc_executa_rota: small behavioural route RAM plus hand-computed expectations
// with T_FLOOR=4 and T_DOOR=5.
module tb_uc_executa_rota;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       insert_busy;
`ifdef DOOR_HOLD_EN
  logic       door_hold;
`endif
  logic [3:0] current_floor;
  logic       move_up;
  logic       move_down;
  logic       door_open;
  logic       bad_stop;
  logic [3:0] state_db;

  uc_executa_rota_if #(.ADDR_W(4)) bus ();

  uc_executa_rota #(
    .N_FLOORS(8),
    .ADDR_W  (4),
    .T_FLOOR (4),
    .T_DOOR  (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .insert_busy  (insert_busy),
`ifdef DOOR_HOLD_EN
    .door_hold    (door_hold),
`endif
    .ram          (bus.master),
    .current_floor(current_floor),
    .move_up      (move_up),
    .move_down    (move_down),
    .door_open    (door_open),
    .bad_stop     (bad_stop),
    .state_db     (state_db)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Route RAM model: {valid, floor[3:0]}, registered read, clear strobe, bench write port.
  logic [4:0] mem [16];
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_floor <= '0;
    end else begin
      {bus.rd_valid, bus.rd_floor} <= mem[bus.head_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
      if (bus.clear_entry) mem[bus.head_addr] <= '0;
    end
  end

  int checks   = 0;
  int failures = 0;

  int cyc, up_n, down_n, door_n, clr_n, bad_n, badclr_n, both_n, doormove_n, max_state;
  int first_up, first_door, fetch_at;
  int floor_log[$];
  logic [3:0] last_floor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic clear_stats();
    up_n = 0; down_n = 0; door_n = 0; clr_n = 0; bad_n = 0; badclr_n = 0;
    both_n = 0; doormove_n = 0; max_state = 0;
    first_up = -1; first_door = -1; fetch_at = -1;
    floor_log.delete();
    last_floor = current_floor;
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
    if (move_up) begin
      up_n++;
      if (first_up < 0) first_up = cyc;
    end
    if (move_down) down_n++;
    if (door_open) begin
      door_n++;
      if (first_door < 0) first_door = cyc;
    end
    if (bus.clear_entry) clr_n++;
    if (bad_stop) bad_n++;
    if (bad_stop && bus.clear_entry) badclr_n++;
    if (move_up && move_down) both_n++;
    if (door_open && (move_up || move_down)) doormove_n++;
    if (int'(state_db) > max_state) max_state = int'(state_db);
    if (state_db == 4'd2 && fetch_at < 0) fetch_at = cyc;
    if (current_floor != last_floor) begin
      floor_log.push_back(int'(current_floor));
      last_floor = current_floor;
    end
  endtask

  task automatic ram_write(input logic [3:0] addr, input logic [3:0] floor);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = {1'b1, floor};
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    iniciar = 1'b0;
    for (int i = 0; i < 300 && state_db != 4'd0; i++) step();
    step();
    check("idle_reached", state_db, 4'd0);
  endtask

  initial begin
    cyc = 0;
    reset = 1'b1;
    iniciar = 1'b0;
    insert_busy = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`ifdef DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    clear_stats();
    step();
    step();

    // Reset state
    check("rst_state", state_db, 4'd0);
    check("rst_head", bus.head_addr, 4'd0);
    check("rst_floor", current_floor, 4'd0);
    check("rst_outs", {move_up, move_down, door_open, bad_stop, bus.clear_entry}, 5'd0);

    // Empty list: IDLE -> READ -> FETCH -> IDLE, no pops
    reset = 1'b0;
    iniciar = 1'b1;
    clear_stats();
    step();
    check("empty_read", state_db, 4'd1);
    step();
    check("empty_fetch", state_db, 4'd2);
    step();
    check("empty_idle", state_db, 4'd0);
    for (int i = 0; i < 27; i++) step();
    check("empty_clears", clr_n, 0);
    check("empty_head", bus.head_addr, 4'd0);
    check("empty_maxstate", max_state, 2);

    // Single stop upward 0 -> 3
    wait_idle();
    ram_write(4'd0, 4'd3);
    clear_stats();
    iniciar = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("up_cycles", up_n, 12);
    check("up_down_cycles", down_n, 0);
    check("up_door_cycles", door_n, 5);
    check("up_door_latency", first_door - first_up, 12);
    check("up_clears", clr_n, 1);
    check("up_head", bus.head_addr, 4'd1);
    check("up_floor", current_floor, 4'd3);
    check("up_floor_steps", floor_log.size(), 3);
    check("up_floor_1", (floor_log.size() > 0) ? floor_log[0] : 99, 1);
    check("up_floor_2", (floor_log.size() > 1) ? floor_log[1] : 99, 2);
    check("up_floor_3", (floor_log.size() > 2) ? floor_log[2] : 99, 3);
    check("up_entry_cleared", mem[0], 5'd0);
    check("up_excl", both_n + doormove_n, 0);

    // Same-floor stop at 3
    wait_idle();
    ram_write(4'd1, 4'd3);
    clear_stats();
    iniciar = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("same_motion", up_n + down_n, 0);
    check("same_door_cycles", door_n, 5);
    check("same_door_latency", first_door - fetch_at, 2);
    check("same_clears", clr_n, 1);
    check("same_head", bus.head_addr, 4'd2);

    // Bad stop (floor 9)
    wait_idle();
    ram_write(4'd2, 4'd9);
    clear_stats();
    iniciar = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("bad_motion", up_n + down_n, 0);
    check("bad_door", door_n, 0);
    check("bad_clears", clr_n, 1);
    check("bad_pulses", bad_n, 1);
    check("bad_with_clear", badclr_n, 1);
    check("bad_head", bus.head_addr, 4'd3);
    check("bad_floor", current_floor, 4'd3);

    // Advance head to 15 via bad stops, then stall the final pop and wrap
    wait_idle();
    for (int a = 3; a < 15; a++) ram_write(4'(a), 4'd15);
    ram_write(4'd15, 4'd3);
    clear_stats();
    iniciar = 1'b1;
    for (int i = 0; i < 400 && bus.head_addr != 4'd15; i++) step();
    check("adv_head", bus.head_addr, 4'd15);
    check("adv_bad_pulses", bad_n, 12);
    insert_busy = 1'b1;
    for (int i = 0; i < 50 && state_db != 4'd7; i++) step();
    check("stall_in_pop", state_db, 4'd7);
    clr_n = 0;
    for (int i = 0; i < 10; i++) step();
    check("stall_no_clear", clr_n, 0);
    check("stall_still_pop", state_db, 4'd7);
    insert_busy = 1'b0;
    #1;
    check("stall_release_clear", bus.clear_entry, 1'b1);
    check("stall_release_head", bus.head_addr, 4'd15);
    step();
    check("wrap_head", bus.head_addr, 4'd0);
    check("wrap_state", state_db, 4'd0);
    check("wrap_entry_cleared", mem[15], 5'd0);

    // Up to 5, then reset while travelling down
    wait_idle();
    ram_write(4'd0, 4'd5);
    ram_write(4'd1, 4'd0);
    clear_stats();
    iniciar = 1'b1;
    for (int i = 0; i < 300 && state_db != 4'd5; i++) step();
    check("down_state", state_db, 4'd5);
    check("down_start_floor", current_floor, 4'd5);
    check("down_prior_up", up_n, 8);
    check("down_move", {move_up, move_down, door_open}, 3'b010);
    step();
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_state", state_db, 4'd0);
    check("mid_rst_floor", current_floor, 4'd0);
    check("mid_rst_head", bus.head_addr, 4'd0);
    check("mid_rst_outs", {move_up, move_down, door_open, bad_stop, bus.clear_entry}, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_executa_rota.md
Name: uc_executa_rota

Overview:
- Downstream consumer of the route RAM that the new-request insertion FSM fills.
- Reads the stop at the head address and drives the cargo car floor by floor to that stop. It then holds the door open for a fixed time, clears the served entry and advances the head pointer.
- Owns `current_floor`. Coordinates RAM access with the insertion FSM through the `insert_busy` input.

Parameters:
- `N_FLOORS`, 8, number of served floors (0..`N_FLOORS`-1).
- `ADDR_W`, 4, route RAM address width; the head pointer wraps at 2^`ADDR_W`.
- `T_FLOOR`, 50, clock cycles to travel one floor.
- `T_DOOR`, 100, clock cycles the door stays open.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `iniciar` in 1: level enable; while 0, no new stop is fetched.
- `insert_busy` in 1: insertion FSM is not in its idle state; RAM writes from this block are forbidden.
- `rd_valid` in 1: occupied bit of the RAM entry at `head_addr` (synchronous RAM, 1-cycle read latency).
- `rd_floor` in 4: floor field of the RAM entry at `head_addr`.
- `head_addr` out `ADDR_W`: read/clear address presented to the route RAM.
- `clear_entry` out 1: 1-cycle write strobe that zeroes the entry at `head_addr`.
- `current_floor` out 4: present car floor.
- `move_up` out 1: car travelling up.
- `move_down` out 1: car travelling down.
- `door_open` out 1: door open.
- `bad_stop` out 1: 1-cycle pulse when a stop ≥ `N_FLOORS` is discarded.
- `state_db` out 4: current state encoding, for debug.

Behaviour:
- Reset values: all outputs 0; state = `IDLE`; travel and door counters = 0.
- States and encodings:
  - `IDLE` 0: if `iniciar`, go to `READ`.
  - `READ` 1: address is stable; go to `FETCH`. This covers the 1-cycle RAM latency.
  - `FETCH` 2: sample `rd_valid`/`rd_floor` into the target register.
    - `!rd_valid` → `IDLE`.
    - `rd_floor` ≥ `N_FLOORS` → `POP` with `bad_stop` flagged.
    - otherwise → `DECIDE`.
  - `DECIDE` 3:
    - target > `current_floor` → `UP`.
    - target < `current_floor` → `DOWN`.
    - equal → `DOOR`.
  - `UP` 4 / `DOWN` 5:
    - `move_up`/`move_down` = 1.
    - Travel counter counts 0..`T_FLOOR`-1. On terminal count, `current_floor` ±1 and the counter clears.
    - Go to `DOOR` on the same cycle the updated floor equals the target; otherwise stay.
  - `DOOR` 6:
    - `door_open` = 1; door counter counts 0..`T_DOOR`-1.
    - Terminal count → `POP`.
  - `POP` 7:
    - Waits while `insert_busy` = 1; no strobe is issued during the wait.
    - When `insert_busy` = 0: `clear_entry` = 1 for exactly that cycle, and `bad_stop` pulses if flagged.
    - `head_addr` increments (mod 2^`ADDR_W`) on the following edge; go to `IDLE`.
- Car motion: `move_up` and `move_down` are never both 1. `door_open` is never 1 while moving.
- `current_floor` saturates at 0 and `N_FLOORS`-1; this cannot be exceeded because the target is range-checked.
- `iniciar` dropping mid-route does not abort; the current stop completes and then `IDLE` holds.
- `insert_busy` only gates `POP`. Reads are always legal.
- An entry inserted behind the head while travelling is picked up at the next `READ`.
- Asynchronous reset mid-travel returns to `IDLE`, floor 0 and head 0. The car position is reinitialised by reset by definition.
- Default/illegal state → `IDLE`.

Optional Feature:
- Macro: `DOOR_HOLD_EN`.
- Enabled:
  - Adds input `door_hold` (1 bit).
  - In `DOOR`, `door_hold` = 1 clears the door counter every cycle, so the door closes `T_DOOR` cycles after the last held cycle.
  - Hold is ignored in all other states.
- Disabled: port absent; the door time is exactly `T_DOOR` cycles.

Test Plan:
- Empty list: reset, `iniciar`=1, `rd_valid`=0 → cycles `IDLE`/`READ`/`FETCH`; `clear_entry` never asserts; `head_addr` stays 0.
- Single stop upward: floor 0, entry {valid, 3}, `T_FLOOR`=4, `T_DOOR`=5 → `move_up` for 12 cycles, `current_floor` 1, 2, 3; `door_open` for 5 cycles; one `clear_entry`; `head_addr` = 1.
- Same-floor stop: `current_floor`=3, entry {valid, 3} → no movement; door opens 2 cycles after `FETCH`; entry popped.
- Bad stop: entry {valid, 9} with `N_FLOORS`=8 → no motion, no door; `bad_stop` and `clear_entry` pulse together; head advances.
- Pop stall plus wrap: `head_addr`=15, `insert_busy`=1 for 10 cycles during `POP` → `clear_entry` asserts on the first cycle with `insert_busy`=0; `head_addr` wraps to 0.
- Reset mid-travel during `DOWN` from floor 5 → all outputs 0 immediately; `state_db`=0; `current_floor`=0.
